// File: rtl/storage_pkg.sv
// Shared defaults and the width helper used to size storage_ring.
package storage_pkg;

    localparam int POINTS_DEF = 10;
    localparam int WIDTH_DEF  = 12;
    localparam int DEPTH_DEF  = 10;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/storage_point_acc.sv
// Running sum for one point: adds the incoming sample and removes the
// evicted one in a single update. sub_val is 0 until the ring is full.
module storage_point_acc #(
    parameter int WIDTH = 12,
    parameter int SUMW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             upd,
    input  logic [WIDTH-1:0] add_val,
    input  logic [WIDTH-1:0] sub_val,
    output logic [SUMW-1:0]  sum
);

    // Sum register: reset/clear flush, otherwise add-new-minus-evicted on update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (upd) begin
            sum <= sum + SUMW'(add_val) - SUMW'(sub_val);
        end
    end

endmodule

// File: rtl/storage_ring.sv
// History ring of the last DEPTH frames with per-point running sums,
// addressed readout by age and a flat newest-first image.
module storage_ring
    import storage_pkg::*;
#(
    parameter  int POINTS = POINTS_DEF,
    parameter  int WIDTH  = WIDTH_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int AW     = clog2(DEPTH),
    localparam int CW     = clog2(DEPTH + 1),
    localparam int SUMW   = WIDTH + clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          store_en,
    input  logic [WIDTH*POINTS-1:0]       store,
    input  logic                          freeze,
    input  logic                          clear,
    input  logic [AW-1:0]                 rd_frame,
    output logic [WIDTH*POINTS-1:0]       rd_data,
    output logic [CW-1:0]                 fill,
    output logic                          full,
    output logic [SUMW*POINTS-1:0]        sum,
    output logic [15:0]                   drop_cnt,
    output logic [WIDTH*POINTS*DEPTH-1:0] storage
);

    localparam int FW = WIDTH * POINTS;

    logic [DEPTH-1:0][FW-1:0] mem;
    logic [AW-1:0]            wr_ptr;
    logic                     accept;
    logic                     drop;

    assign accept = store_en & ~freeze & ~clear;
    assign drop   = store_en &  freeze & ~clear;
    assign full   = (fill == CW'(DEPTH));

    // Slot holding frame of age a: (ptr-1-a) mod DEPTH. Only meaningful for
    // a < fill, which callers guarantee before using the result.
    function automatic logic [AW-1:0] age_slot(input logic [AW-1:0] ptr,
                                               input logic [AW-1:0] a);
        logic [AW+1:0] t;
        t = {2'b00, ptr} + (AW+2)'(DEPTH - 1) - {2'b00, a};
        if (t >= (AW+2)'(DEPTH)) t = t - (AW+2)'(DEPTH);
        return t[AW-1:0];
    endfunction

    // Ring write, write pointer and fill level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            fill   <= '0;
        end else if (clear) begin
            mem    <= '0;
            wr_ptr <= '0;
            fill   <= '0;
        end else if (accept) begin
            mem[wr_ptr] <= store;
            wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            if (!full) fill <= fill + CW'(1);
        end
    end

    // Frozen store strobes, saturating; clear holds the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Registered readout from the pre-write state; ages beyond fill read 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= (CW'(rd_frame) < fill) ? mem[age_slot(wr_ptr, rd_frame)] : '0;
        end
    end

    // Flat image, age 0 in the LSBs; empty ages are masked to 0.
    for (genvar a = 0; a < DEPTH; a++) begin : g_age
        assign storage[FW*a +: FW] = (CW'(a) < fill) ? mem[age_slot(wr_ptr, AW'(a))] : '0;
    end

    // Per-point accumulators; the slot at wr_ptr is the one being evicted once full.
    for (genvar k = 0; k < POINTS; k++) begin : g_pt
        logic [WIDTH-1:0] old_v;
        assign old_v = full ? mem[wr_ptr][WIDTH*k +: WIDTH] : '0;

        storage_point_acc #(
            .WIDTH (WIDTH),
            .SUMW  (SUMW)
        ) u_acc (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (clear),
            .upd     (accept),
            .add_val (store[WIDTH*k +: WIDTH]),
            .sub_val (old_v),
            .sum     (sum[SUMW*k +: SUMW])
        );
    end

endmodule

// File: tb/tb_storage_ring.sv
// Directed table-driven bench for storage_ring (POINTS=2, WIDTH=12, DEPTH=4).
module tb_storage_ring;

    localparam int POINTS = 2;
    localparam int WIDTH  = 12;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        store_en;
    logic [23:0] store;
    logic        freeze;
    logic        clear;
    logic [1:0]  rd_frame;
    logic [23:0] rd_data;
    logic [2:0]  fill;
    logic        full;
    logic [27:0] sum;
    logic [15:0] drop_cnt;
    logic [95:0] storage;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    storage_ring #(.POINTS(POINTS), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .store_en (store_en),
        .store    (store),
        .freeze   (freeze),
        .clear    (clear),
        .rd_frame (rd_frame),
        .rd_data  (rd_data),
        .fill     (fill),
        .full     (full),
        .sum      (sum),
        .drop_cnt (drop_cnt),
        .storage  (storage)
    );

    typedef struct {
        logic       en, frz, clr;
        logic [11:0] p0, p1;
        logic [1:0] rd;
        int         fill, s0, s1, r0, r1, drop;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic en, frz, clr, input int p0, p1, rd,
                                input int f, s0, s1, r0, r1, d);
        vec_t v;
        v.en = en; v.frz = frz; v.clr = clr;
        v.p0 = 12'(p0); v.p1 = 12'(p1); v.rd = 2'(rd);
        v.fill = f; v.s0 = s0; v.s1 = s1; v.r0 = r0; v.r1 = r1; v.drop = d;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        store_en = 1'b0; freeze = 1'b0; clear = 1'b0; store = '0; rd_frame = '0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " fill"},    128'(fill), 0);
        chk({tag, " full"},    128'(full), 0);
        chk({tag, " sum"},     128'(sum), 0);
        chk({tag, " storage"}, 128'(storage), 0);
        chk({tag, " rd_data"}, 128'(rd_data), 0);
        chk({tag, " drop"},    128'(drop_cnt), 0);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            store_en = tbl[i].en; freeze = tbl[i].frz; clear = tbl[i].clr;
            store = {tbl[i].p1, tbl[i].p0}; rd_frame = tbl[i].rd;
            step();
            chk($sformatf("r%0d fill", i), 128'(fill), 128'(tbl[i].fill));
            chk($sformatf("r%0d full", i), 128'(full), 128'(tbl[i].fill == DEPTH));
            chk($sformatf("r%0d sum0", i), 128'(sum[13:0]), 128'(tbl[i].s0));
            chk($sformatf("r%0d sum1", i), 128'(sum[27:14]), 128'(tbl[i].s1));
            chk($sformatf("r%0d rd0", i),  128'(rd_data[11:0]), 128'(tbl[i].r0));
            chk($sformatf("r%0d rd1", i),  128'(rd_data[23:12]), 128'(tbl[i].r1));
            chk($sformatf("r%0d drop", i), 128'(drop_cnt), 128'(tbl[i].drop));
        end
        idle_inputs();
    endtask

    initial begin
        logic [95:0] exp_img;

        //                en frz clr p0  p1 rd   fill s0  s1  r0 r1 drop
        tbl[0]  = mk(1, 0, 0,  1, 10, 0,   1,  1,  10,  0,  0, 0);
        tbl[1]  = mk(1, 0, 0,  2, 20, 0,   2,  3,  30,  1, 10, 0);
        tbl[2]  = mk(1, 0, 0,  3, 30, 0,   3,  6,  60,  2, 20, 0);
        tbl[3]  = mk(0, 0, 0,  0,  0, 0,   3,  6,  60,  3, 30, 0);
        tbl[4]  = mk(0, 0, 0,  0,  0, 3,   3,  6,  60,  0,  0, 0);
        tbl[5]  = mk(0, 0, 0,  0,  0, 2,   3,  6,  60,  1, 10, 0);
        tbl[6]  = mk(1, 0, 0,  4, 40, 0,   4, 10, 100,  3, 30, 0);
        tbl[7]  = mk(1, 0, 0,  5, 50, 0,   4, 14, 140,  4, 40, 0);
        tbl[8]  = mk(1, 0, 0,  6, 60, 0,   4, 18, 180,  5, 50, 0);
        tbl[9]  = mk(0, 0, 0,  0,  0, 3,   4, 18, 180,  3, 30, 0);
        tbl[10] = mk(1, 1, 0, 99, 99, 0,   4, 18, 180,  6, 60, 1);
        tbl[11] = mk(1, 1, 0, 99, 99, 0,   4, 18, 180,  6, 60, 2);
        tbl[12] = mk(1, 1, 0, 99, 99, 1,   4, 18, 180,  5, 50, 3);
        tbl[13] = mk(1, 0, 1,  9,  9, 0,   0,  0,   0,  6, 60, 3);
        tbl[14] = mk(1, 0, 0,  7,  7, 0,   1,  7,   7,  0,  0, 3);
        tbl[15] = mk(0, 0, 0,  0,  0, 0,   1,  7,   7,  7,  7, 3);
        tbl[16] = mk(1, 1, 1,  8,  8, 0,   0,  0,   0,  7,  7, 3);
        tbl[17] = mk(0, 0, 0,  0,  0, 0,   0,  0,   0,  0,  0, 3);

        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check_zero("reset");

        // Partial fill, wrap into eviction, idle readback.
        run_rows(0, 9);
        exp_img = {12'd30, 12'd3, 12'd40, 12'd4, 12'd50, 12'd5, 12'd60, 12'd6};
        chk("storage full ring", 128'(storage), 128'(exp_img));
        chk("storage lsb p0", 128'(storage[11:0]), 6);
        chk("storage msb p0", 128'(storage[83:72]), 3);

        // Freeze drops, then clear interactions.
        run_rows(10, 17);

        // Saturation of the drop counter.
        @(negedge clk);
        force dut.drop_cnt = 16'hFFFF;
        #1;
        release dut.drop_cnt;
        #1;
        chk("drop preload", 128'(drop_cnt), 16'hFFFF);
        store_en = 1'b1; freeze = 1'b1; store = 24'h123123;
        step();
        chk("drop saturate", 128'(drop_cnt), 16'hFFFF);
        chk("drop frozen fill", 128'(fill), 0);
        idle_inputs();

        // Max-value frames, then reset in the middle of a store.
        for (int i = 0; i < 4; i++) begin
            store_en = 1'b1; store = {12'hFFF, 12'hFFF};
            step();
        end
        chk("max sum0", 128'(sum[13:0]), 16380);
        chk("max sum1", 128'(sum[27:14]), 16380);
        chk("max full", 128'(full), 1);
        store = {12'd5, 12'd5};
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle_inputs();
        check_zero("midreset");
        step();
        check_zero("postreset");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
